// File: rtl/csc_rgb_packer_if.sv
// Pixel input handshake and SRAM write port of the colour-space conversion / packing stage.
interface csc_rgb_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_y;
    logic [7:0]  in_u;
    logic [7:0]  in_v;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    // Upstream pixel source and SRAM observer
    modport master (
        output in_valid, in_y, in_u, in_v,
        input  in_ready, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    // Conversion / packing stage
    modport slave (
        input  in_valid, in_y, in_u, in_v,
        output in_ready, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/csc_rgb_packer.sv
// YUV -> RGB888 conversion (3-stage pipeline) and packing of pixel pairs into
// three 16-bit SRAM words written sequentially from RGB_BASE.
module csc_rgb_packer #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int unsigned NUM_PIXELS = 76800
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    csc_rgb_packer_if.slave         bus
);

    localparam int unsigned CNT_W = $clog2(NUM_PIXELS + 1);
    localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_PIXELS);

    localparam logic signed [31:0] C_Y  = 32'sd76284;
    localparam logic signed [31:0] C_RV = 32'sd104595;
    localparam logic signed [31:0] C_GU = 32'sd25624;
    localparam logic signed [31:0] C_GV = 32'sd53281;
    localparam logic signed [31:0] C_BU = 32'sd132251;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {P_EVEN, P_ODD, P_LAST} pk_t;

    state_t           r_state, w_state_nxt;
    pk_t              r_pk, w_pk_nxt;
    logic             r_busy, r_done, w_busy_nxt, w_done_nxt, w_start_acc;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             w_stall, w_xfer, w_pipe_empty;

    logic                r_vld1, r_vld2, r_vld3;
    logic signed [8:0]   r_ys1, r_us1, r_vs1;
    logic signed [31:0]  r_r2, r_g2, r_b2;
    logic [7:0]          r_r3, r_g3, r_b3;
    logic signed [31:0]  w_ye, w_ue, w_ve;

    logic [7:0]  r_sav_g, r_sav_b;
    logic        w_wr;
    logic [15:0] w_wdata;
    logic        r_we_n;
    logic [17:0] r_addr, r_wr_ptr;
    logic [15:0] r_wdata;

    // Floor shift by 16 then saturate to 0..255
    function automatic logic [7:0] clip8(input logic signed [31:0] s);
        logic signed [31:0] t;
        t = s >>> 16;
        if (t < 0)
            return 8'd0;
        else if (t > 32'sd255)
            return 8'hFF;
        else
            return t[7:0];
    endfunction

    // Only the P_LAST word is written without consuming S3, so that is the only stall
    assign w_stall      = (r_pk == P_LAST) & r_vld3;
    assign bus.in_ready = (r_state == S_RUN) & (r_acc_cnt < NUM_C) & ~w_stall;
    assign w_xfer       = bus.in_valid & bus.in_ready;
    assign w_pipe_empty = ~(r_vld1 | r_vld2 | r_vld3);

    assign busy                = r_busy;
    assign done                = r_done;
    assign bus.SRAM_we_n       = r_we_n;
    assign bus.SRAM_address    = r_addr;
    assign bus.SRAM_write_data = r_wdata;

    // Top FSM next-state and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (r_acc_cnt == NUM_C)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pipe_empty && (r_pk == P_EVEN)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Top FSM state, status flags and accepted-pixel counter
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_start_acc)
                r_acc_cnt <= '0;
            else if (w_xfer)
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        end
    end

    assign w_ye = {{23{r_ys1[8]}}, r_ys1};
    assign w_ue = {{23{r_us1[8]}}, r_us1};
    assign w_ve = {{23{r_vs1[8]}}, r_vs1};

    // Three-stage conversion pipeline; all stages hold together on stall
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_vld1 <= 1'b0;
            r_vld2 <= 1'b0;
            r_vld3 <= 1'b0;
            r_ys1  <= '0;
            r_us1  <= '0;
            r_vs1  <= '0;
            r_r2   <= '0;
            r_g2   <= '0;
            r_b2   <= '0;
            r_r3   <= '0;
            r_g3   <= '0;
            r_b3   <= '0;
        end else if (!w_stall) begin
            r_vld1 <= w_xfer;
            if (w_xfer) begin
                r_ys1 <= $signed({1'b0, bus.in_y}) - 9'sd16;
                r_us1 <= $signed({1'b0, bus.in_u}) - 9'sd128;
                r_vs1 <= $signed({1'b0, bus.in_v}) - 9'sd128;
            end
            r_vld2 <= r_vld1;
            r_r2   <= C_Y * w_ye + C_RV * w_ve;
            r_g2   <= C_Y * w_ye - C_GU * w_ue - C_GV * w_ve;
            r_b2   <= C_Y * w_ye + C_BU * w_ue;
            r_vld3 <= r_vld2;
            r_r3   <= clip8(r_r2);
            r_g3   <= clip8(r_g2);
            r_b3   <= clip8(r_b2);
        end
    end

    // Packer next-state and word selection
    always_comb begin
        w_pk_nxt = r_pk;
        w_wr     = 1'b0;
        w_wdata  = 16'h0000;
        case (r_pk)
            P_EVEN: begin
                if (r_vld3) begin
                    w_wr     = 1'b1;
                    w_wdata  = {r_r3, r_g3};
                    w_pk_nxt = P_ODD;
                end
            end
            P_ODD: begin
                if (r_vld3) begin
                    w_wr     = 1'b1;
                    w_wdata  = {r_sav_b, r_r3};
                    w_pk_nxt = P_LAST;
                end
            end
            P_LAST: begin
                w_wr     = 1'b1;
                w_wdata  = {r_sav_g, r_sav_b};
                w_pk_nxt = P_EVEN;
            end
            default: w_pk_nxt = P_EVEN;
        endcase
    end

    // Packer state, carried channels and registered SRAM write port
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_pk     <= P_EVEN;
            r_sav_g  <= '0;
            r_sav_b  <= '0;
            r_we_n   <= 1'b1;
            r_addr   <= '0;
            r_wr_ptr <= '0;
            r_wdata  <= '0;
        end else begin
            r_pk   <= w_pk_nxt;
            r_we_n <= ~w_wr;
            if (r_pk == P_EVEN && r_vld3)
                r_sav_b <= r_b3;
            if (r_pk == P_ODD && r_vld3) begin
                r_sav_g <= r_g3;
                r_sav_b <= r_b3;
            end
            if (w_start_acc) begin
                r_wr_ptr <= RGB_BASE;
                r_addr   <= RGB_BASE;
            end else if (w_wr) begin
                r_addr   <= r_wr_ptr;
                r_wdata  <= w_wdata;
                r_wr_ptr <= r_wr_ptr + 18'd1;
            end
        end
    end

endmodule

// File: tb/tb_csc_rgb_packer.sv
// Self-checking bench for csc_rgb_packer: directed colour cases, back-to-back
// streaming, random bubbles and mid-frame reset, checked against a YUV->RGB model.
module tb_csc_rgb_packer;

    localparam int unsigned NPIX   = 6;
    localparam int unsigned NWORDS = NPIX * 3 / 2;
    localparam logic [17:0] BASE   = 18'd146944;

    logic Clock = 1'b0;
    logic Resetn;
    logic start;
    logic busy;
    logic done;

    csc_rgb_packer_if bus();

    csc_rgb_packer #(.RGB_BASE(BASE), .NUM_PIXELS(NPIX)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #10 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [23:0] px_q[$];
    logic [17:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          acc_cyc_q[$];
    int          done_cnt;
    bit          ready_after_last;

    // Observe SRAM writes, acceptances and done pulses mid-cycle
    always @(negedge Clock) begin
        if (Resetn) begin
            if (!bus.SRAM_we_n) begin
                wr_addr_q.push_back(bus.SRAM_address);
                wr_data_q.push_back(bus.SRAM_write_data);
                wr_cyc_q.push_back(cyc);
            end
            if (done) done_cnt++;
            if (bus.in_ready && acc_cyc_q.size() >= NPIX) ready_after_last = 1'b1;
            if (bus.in_valid && bus.in_ready) acc_cyc_q.push_back(cyc + 1);
        end
    end

    function automatic logic [7:0] clip(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Reference colour conversion with plain integer arithmetic
    function automatic logic [23:0] to_rgb(input logic [23:0] yuv);
        int y, u, v;
        y = int'(yuv[23:16]) - 16;
        u = int'(yuv[15:8]) - 128;
        v = int'(yuv[7:0]) - 128;
        return {clip((76284 * y + 104595 * v) >>> 16),
                clip((76284 * y - 25624 * u - 53281 * v) >>> 16),
                clip((76284 * y + 132251 * u) >>> 16)};
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
        done_cnt = 0;
        ready_after_last = 1'b0;
    endtask

    task automatic do_start();
        @(posedge Clock); #1 start = 1'b1;
        @(posedge Clock); #1 start = 1'b0;
    endtask

    task automatic random_pixels();
        px_q.delete();
        for (int i = 0; i < NPIX; i++) px_q.push_back(24'($urandom));
    endtask

    task automatic drive(input bit gaps);
        int  idx = 0;
        int  guard = 0;
        bit  acc;
        while (idx < px_q.size() && guard < 2000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                {bus.in_y, bus.in_u, bus.in_v} = 24'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                {bus.in_y, bus.in_u, bus.in_v} = px_q[idx];
            end
            @(negedge Clock);
            acc = bus.in_valid && bus.in_ready;
            @(posedge Clock); #1;
            if (acc) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (idx != px_q.size()) begin
            errors++;
            $display("FAIL drive_accept: accepted %0d pixels, required %0d", idx, px_q.size());
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        repeat (5) @(negedge Clock);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done: done pulses %0d, required 1", tag, done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: busy %b, required 0", tag, busy);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [15:0] ew[$];
        logic [23:0] a, b;
        for (int k = 0; k < NPIX / 2; k++) begin
            a = to_rgb(px_q[2*k]);
            b = to_rgb(px_q[2*k+1]);
            ew.push_back({a[23:16], a[15:8]});
            ew.push_back({a[7:0], b[23:16]});
            ew.push_back({b[15:8], b[7:0]});
        end
        checks++;
        if (wr_data_q.size() != NWORDS) begin
            errors++;
            $display("FAIL %s_count: writes %0d, required %0d", tag, wr_data_q.size(), NWORDS);
        end
        for (int i = 0; i < NWORDS && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== BASE + 18'(i) || wr_data_q[i] !== ew[i]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h@%0d, required %h@%0d",
                         tag, i, wr_data_q[i], wr_addr_q[i], ew[i], BASE + 18'(i));
            end
        end
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        clear_log();
        do_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_start: busy %b, required 1", tag, busy);
        end
        drive(gaps);
        wait_done(tag);
        check_frame(tag);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        {bus.in_y, bus.in_u, bus.in_v} = 24'h0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data} !== {1'b1, 18'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_sram: we_n=%b addr=%0d data=%h, required 1/0/0000",
                     bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data);
        end
        checks++;
        if ({bus.in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b done=%b, required 000",
                     bus.in_ready, busy, done);
        end
        @(posedge Clock); #2 Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if ({bus.SRAM_we_n, bus.in_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset: we_n=%b in_ready=%b busy=%b, required 100",
                     bus.SRAM_we_n, bus.in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [15:0] exp_w [NWORDS];
        exp_w = '{16'h0000, 16'h00FE, 16'hFEFE, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                  16'hCA00, 16'h0000, 16'h0000};
        px_q = '{{8'd16, 8'd128, 8'd128}, {8'd235, 8'd128, 8'd128},
                 {8'd255, 8'd128, 8'd128}, {8'd255, 8'd128, 8'd128},
                 {8'd16, 8'd128, 8'd255}, {8'd0, 8'd128, 8'd128}};
        run_frame("directed", 1'b0);
        for (int i = 0; i < NWORDS && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL directed_const%0d: got %h, required %h", i, wr_data_q[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        random_pixels();
        run_frame("b2b", 1'b0);
        checks++;
        if (wr_cyc_q.size() != NWORDS || acc_cyc_q.size() != NPIX) begin
            errors++;
            $display("FAIL b2b_logs: writes %0d accepts %0d, required %0d/%0d",
                     wr_cyc_q.size(), acc_cyc_q.size(), NWORDS, NPIX);
        end else begin
            checks++;
            if (wr_cyc_q[0] != acc_cyc_q[0] + 3) begin
                errors++;
                $display("FAIL b2b_latency: first write edge %0d, required %0d",
                         wr_cyc_q[0], acc_cyc_q[0] + 3);
            end
            checks++;
            if (wr_cyc_q[NWORDS-1] - wr_cyc_q[0] != NWORDS - 1) begin
                errors++;
                $display("FAIL b2b_contig: write span %0d cycles, required %0d",
                         wr_cyc_q[NWORDS-1] - wr_cyc_q[0] + 1, NWORDS);
            end
            // Only the first pair's P_LAST cycle falls inside a 6-pixel acceptance window
            checks++;
            if (acc_cyc_q[NPIX-1] - acc_cyc_q[0] + 1 != NPIX + 1) begin
                errors++;
                $display("FAIL b2b_ready_gap: accept span %0d cycles, required %0d",
                         acc_cyc_q[NPIX-1] - acc_cyc_q[0] + 1, NPIX + 1);
            end
        end
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 3; f++) begin
            random_pixels();
            run_frame($sformatf("gaps%0d", f), 1'b1);
            checks++;
            if (ready_after_last) begin
                errors++;
                $display("FAIL gaps%0d_ready_after_last: in_ready 1 after last accept, required 0", f);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen = 1'b0;
        clear_log();
        do_start();
        bus.in_valid = 1'b1;
        {bus.in_y, bus.in_u, bus.in_v} = {8'd100, 8'd90, 8'd200};
        @(posedge Clock); #1 bus.in_valid = 1'b0;
        while (!seen && n < 20) begin
            @(negedge Clock);
            seen = !bus.SRAM_we_n;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_first_write: no write within %0d cycles, required one", n);
        end
        #1 Resetn = 1'b0;
        #1;
        checks++;
        if ({bus.SRAM_we_n, busy, bus.in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset: we_n=%b busy=%b in_ready=%b, required 100",
                     bus.SRAM_we_n, busy, bus.in_ready);
        end
        repeat (2) @(posedge Clock);
        #5 Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL mid_no_done: done pulses %0d, required 0", done_cnt);
        end
        random_pixels();
        run_frame("after_reset", 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
